// File: rtl/rr_pattern_scan_ctrl_if.sv
// Request/result bundle between the channel producers and the shared pattern scanner.
interface rr_pattern_scan_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 8,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*WORD_W-1:0] word_in;
    logic [PAT_W-1:0]         pattern;
    logic [NUM_CH-1:0]        grant;
    logic                     busy;
    logic                     bit_out;
    logic                     match;
    logic                     done;
    logic [CH_W-1:0]          done_ch;
    logic [CNT_W-1:0]         match_cnt;

    modport master (
        output req, word_in, pattern,
        input  grant, busy, bit_out, match, done, done_ch, match_cnt
    );

    modport slave (
        input  req, word_in, pattern,
        output grant, busy, bit_out, match, done, done_ch, match_cnt
    );
endinterface

// File: rtl/rr_pattern_scan_ctrl.sv
// Round-robin arbiter sharing one serial MSB-first pattern detector between NUM_CH channels.
//
// state | meaning
// IDLE  | waiting for a request; result of the last scan held
// SHIFT | one bit of the captured word enters the detector per clock
// DONE  | one-cycle done pulse, grant still held
module rr_pattern_scan_ctrl #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 8,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rr_pattern_scan_ctrl_if.slave bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int BIT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [CH_W-1:0]   ptr;
    logic [WORD_W-1:0] sh_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [BIT_W-1:0]  bit_cnt;

    logic              win_found;
    logic [CH_W-1:0]   win_idx;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic              match_nxt;

    // Search starts one past the last owner so a held request queues behind the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!win_found && bus.req[(int'(ptr) + i) % NUM_CH]) begin
                win_found = 1'b1;
                win_idx   = CH_W'((int'(ptr) + i) % NUM_CH);
            end
        end
    end

    assign hist_nxt  = {hist[PAT_W-2:0], sh_reg[WORD_W-1]};
    assign fill_nxt  = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    assign match_nxt = (hist_nxt == pat_reg) && (fill_nxt == FILL_W'(PAT_W));

    assign bus.bit_out = sh_reg[WORD_W-1];
    assign bus.match   = (hist == pat_reg) && (fill == FILL_W'(PAT_W));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= CH_W'(NUM_CH - 1);
            sh_reg        <= '0;
            pat_reg       <= '0;
            hist          <= '0;
            fill          <= '0;
            bit_cnt       <= '0;
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_ch   <= '0;
            bus.match_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (win_found) begin
                        bus.grant     <= NUM_CH'(1) << win_idx;
                        bus.busy      <= 1'b1;
                        ptr           <= win_idx;
                        sh_reg        <= bus.word_in[win_idx*WORD_W +: WORD_W];
                        pat_reg       <= bus.pattern;
                        hist          <= '0;
                        fill          <= '0;
                        bit_cnt       <= BIT_W'(WORD_W - 1);
                        bus.match_cnt <= '0;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist   <= hist_nxt;
                    sh_reg <= sh_reg << 1;
                    fill   <= fill_nxt;
                    if (match_nxt && (bus.match_cnt != '1))
                        bus.match_cnt <= bus.match_cnt + CNT_W'(1);
                    if (bit_cnt == '0) begin
                        bus.done    <= 1'b1;
                        bus.done_ch <= ptr;
                        state       <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end
                end
                DONE: begin
                    bus.done  <= 1'b0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_pattern_scan_ctrl.sv
// Bench for rr_pattern_scan_ctrl: vector table plus scoreboard of done results, and hand sequences.
module tb_rr_pattern_scan_ctrl;
    localparam int NUM_CH = 4;
    localparam int WORD_W = 8;
    localparam int PAT_W  = 3;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rr_pattern_scan_ctrl_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
    rr_pattern_scan_ctrl_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) bus2 ();

    rr_pattern_scan_ctrl #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    rr_pattern_scan_ctrl #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    typedef struct {
        int         ch;
        logic [7:0] w;
        logic [2:0] p;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        int ch;
        int cnt;
    } sb_t;

    vec_t vecs[7];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_cnt(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p, input int cmax);
        int n;
        logic [PAT_W-1:0] win;
        n = 0;
        for (int k = PAT_W; k <= WORD_W; k++) begin
            win = w[WORD_W-k +: PAT_W];
            if (win == p) n++;
        end
        if (n > cmax) n = cmax;
        return n;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding scan.
    always @(negedge clk) begin
        if (bus.done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done_ch=%0d with no scan pending", bus.done_ch);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_done_ch", 32'(bus.done_ch), 32'(e.ch));
                check("sb_match_cnt", 32'(bus.match_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_bit_out"}, 32'(bus.bit_out), 0);
        check({tag, "_match"}, 32'(bus.match), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_done_ch"}, 32'(bus.done_ch), 0);
        check({tag, "_match_cnt"}, 32'(bus.match_cnt), 0);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3 * WORD_W; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        @(negedge clk);
    endtask

    // Single scan; word, pattern and req are scrambled once the word has been captured.
    task automatic run_scan(input int ch, input logic [7:0] w, input logic [2:0] p, input int exp_cnt);
        bit granted;
        sb_t e;
        bus.word_in = {$urandom, $urandom};
        bus.word_in[ch*WORD_W +: WORD_W] = w;
        bus.pattern = p;
        bus.req = NUM_CH'(1) << ch;
        e.ch = ch;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        granted = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                granted = 1'b1;
                break;
            end
        end
        check("vec_grant", 32'(bus.grant), 32'(1) << ch);
        bus.req = '0;
        bus.pattern = ~p;
        bus.word_in = ~bus.word_in;
        if (granted) wait_done("vec");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_W-1:0] ow;
        logic [8:0]        exp_m;
        logic [7:0]        rw;
        logic [2:0]        rp;
        int                rc, raw, start_done;
        bit                multi, g2, fin;
        sb_t               e;

        vecs[0] = '{0, 8'b1010_1101, 3'b101, 3};
        vecs[1] = '{1, 8'hFF,        3'b111, 6};
        vecs[2] = '{2, 8'hFF,        3'b000, 0};
        vecs[3] = '{3, 8'h00,        3'b000, 6};
        vecs[4] = '{1, 8'b0110_1100, 3'b110, 2};
        vecs[5] = '{3, 8'b1001_0010, 3'b001, 2};
        vecs[6] = '{0, 8'b1110_0011, 3'b011, 1};

        reset_n = 1'b0;
        bus.req = '0;  bus.word_in = '0;  bus.pattern = '0;
        bus2.req = '0; bus2.word_in = '0; bus2.pattern = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Timing: cycle 0 presents req[2]; grant/busy cycles 1..9, done in 9, idle in 10.
        bus.word_in[2*WORD_W +: WORD_W] = 8'hFF;
        bus.pattern = 3'b000;
        bus.req = 4'b0100;
        e.ch = 2; e.cnt = 0;
        sb_q.push_back(e);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("tim_grant", 32'(bus.grant), (c <= 9) ? 32'h4 : 32'h0);
            check("tim_busy", 32'(bus.busy), (c <= 9) ? 1 : 0);
            check("tim_done", 32'(bus.done), (c == 9) ? 1 : 0);
            if (c == 9) begin
                check("tim_done_ch", 32'(bus.done_ch), 2);
                check("tim_match_cnt", 32'(bus.match_cnt), 0);
            end
            if (c == 10) bus.req = '0;
        end
        @(negedge clk);

        // Overlap trace: match follows bits 3, 5 and 8; bit_out walks the word MSB-first.
        ow = 8'b1010_1101;
        exp_m = 9'b1_0010_1000;
        bus.word_in[0 +: WORD_W] = ow;
        bus.pattern = 3'b101;
        bus.req = 4'b0001;
        e.ch = 0; e.cnt = 3;
        sb_q.push_back(e);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 8) check("ovl_bit_out", 32'(bus.bit_out), 32'(ow[WORD_W-c]));
            check("ovl_match", 32'(bus.match), 32'(exp_m[c-1]));
            if (c == 1) begin
                bus.req = '0;
                bus.pattern = 3'b010;
                bus.word_in = '1;
            end
        end
        check("ovl_final_cnt", 32'(bus.match_cnt), 3);
        @(negedge clk);
        @(negedge clk);
        check("ovl_hold_cnt", 32'(bus.match_cnt), 3);
        check("ovl_hold_ch", 32'(bus.done_ch), 0);

        for (int i = 0; i < 7; i++)
            run_scan(vecs[i].ch, vecs[i].w, vecs[i].p, vecs[i].exp_cnt);

        for (int i = 0; i < 4; i++) begin
            rc = $urandom_range(NUM_CH - 1);
            rw = 8'($urandom);
            rp = 3'($urandom);
            run_scan(rc, rw, rp, model_cnt(rw, rp, (1 << CNT_W) - 1));
        end

        // Round robin from reset with req=1011 held: 0,1,3,0,1,3.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++)
            bus.word_in[ch*WORD_W +: WORD_W] = 8'($urandom);
        bus.pattern = 3'b010;
        for (int r = 0; r < 6; r++) begin
            int seq_ch;
            seq_ch = (r % 3 == 2) ? 3 : (r % 3);
            e.ch = seq_ch;
            e.cnt = model_cnt(bus.word_in[seq_ch*WORD_W +: WORD_W], 3'b010, (1 << CNT_W) - 1);
            sb_q.push_back(e);
        end
        start_done = n_done;
        multi = 1'b0; g2 = 1'b0; fin = 1'b0;
        bus.req = 4'b1011;
        for (int c = 0; c < 8 * (WORD_W + 2); c++) begin
            @(negedge clk);
            if ((bus.grant & (bus.grant - 1'b1)) != '0) multi = 1'b1;
            if (bus.grant[2]) g2 = 1'b1;
            if (n_done - start_done >= 6) begin
                bus.req = '0;
                fin = 1'b1;
                break;
            end
        end
        check("rr_six_dones", 32'(fin), 1);
        check("rr_multi_hot", 32'(multi), 0);
        check("rr_ch2_granted", 32'(g2), 0);
        repeat (WORD_W + 4) @(negedge clk);
        check("rr_queue_drained", 32'(sb_q.size()), 0);

        // Reset during the 4th SHIFT cycle: no done, outputs cleared, then ch1 wins for req=0110.
        bus.word_in[0 +: WORD_W] = 8'hA5;
        bus.word_in[1*WORD_W +: WORD_W] = 8'b0011_1001;
        bus.pattern = 3'b001;
        bus.req = 4'b0001;
        repeat (4) @(negedge clk);
        check("rst_mid_busy_before", 32'(bus.busy), 1);
        reset_n = 1'b0;
        bus.req = 4'b0110;
        @(negedge clk);
        check_all_zero("rst_mid");
        e.ch = 1; e.cnt = model_cnt(8'b0011_1001, 3'b001, (1 << CNT_W) - 1);
        sb_q.push_back(e);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant", 32'(bus.grant), 32'h2);
        bus.req = '0;
        wait_done("rst");

        // Saturation on the CNT_W=2 instance: six raw matches, count stops at 3.
        bus2.word_in = '0;
        bus2.pattern = 3'b000;
        bus2.req = 4'b0001;
        raw = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (bus2.busy && bus2.match) raw++;
            if (c == 1) bus2.req = '0;
            if (c == 9) begin
                check("sat_done", 32'(bus2.done), 1);
                check("sat_match_cnt", 32'(bus2.match_cnt), 3);
            end
        end
        check("sat_raw_matches", 32'(raw), 6);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_pattern_scan_ctrl.md
Name: rr_pattern_scan_ctrl

Overview:
- Round-robin scheduler that shares one serial Moore-style pattern detector among NUM_CH requesters.
- Each granted requester's parallel word is captured, then shifted MSB-first through the detector, one bit per clock.
- Overlapping occurrences of a PAT_W-bit pattern are counted, and the result is reported with a one-cycle done pulse.
- Sits between the channel producers and the status/interrupt logic.

Parameters:
- NUM_CH, 4: number of requesters (≥2).
- WORD_W, 8: bits per scanned word.
- PAT_W, 3: pattern length (2 ≤ PAT_W ≤ WORD_W).
- CNT_W, 4: match counter width (saturating).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_CH  per-channel scan request (level).
- word_in  in  NUM_CH*WORD_W  channel words; channel i occupies bits [i*WORD_W +: WORD_W].
- pattern  in  PAT_W  target pattern; first bit received is MSB.
- grant  out  NUM_CH  one-hot, owner of the detector.
- busy  out  1  high in SHIFT and DONE.
- bit_out  out  1  bit currently entering the detector (sh_reg MSB).
- match  out  1  Moore output: history window == latched pattern and window full.
- done  out  1  one-cycle pulse, result valid.
- done_ch  out  clog2(NUM_CH)  index of the channel just completed.
- match_cnt  out  CNT_W  matches found in the last word.

Behaviour:
- Reset: clk with reset_n=0 forces state=IDLE. All outputs go to 0: grant, busy, bit_out, match, done, done_ch, match_cnt. Round-robin pointer resets to NUM_CH-1, so ch0 has first priority. Reset mid-scan aborts the scan and produces no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with req≠0 at edge: pick the first set req searching ptr+1, ptr+2, … modulo NUM_CH. Then:
  - set grant one-hot; ptr ← winner;
  - sh_reg ← word of winner; pat_reg ← pattern;
  - clear hist, fill counter, bit counter and match_cnt;
  - go to SHIFT.
- IDLE with req=0: stay in IDLE, outputs hold, done=0.
- SHIFT lasts exactly WORD_W cycles. Each edge:
  - hist ← {hist[PAT_W-2:0], sh_reg[MSB]}; sh_reg ← sh_reg<<1;
  - fill saturates at PAT_W;
  - if next hist == pat_reg and next fill == PAT_W, match_cnt increments, saturating at 2^CNT_W-1.
  - After the WORD_W-th shift, go to DONE.
- DONE, one cycle: done=1, done_ch=ptr, match_cnt final, grant still asserted. Next edge: grant←0, busy←0, go to IDLE.
- Latency: req sampled in IDLE at cycle t → grant/busy high for cycles t+1 … t+WORD_W+1 → done at t+WORD_W+1 → IDLE at t+WORD_W+2. Per-word period is WORD_W+2 cycles.
- Overlapping matches count. Maximum count is WORD_W-PAT_W+1.
- match_cnt and done_ch hold after DONE until the next capture.
- req, word_in and pattern changes during SHIFT/DONE are ignored; a req drop does not abort the scan. A req held high re-enters arbitration, behind other pending channels.
- match is registered-state only, with no combinational path from inputs.

Test Plan:
- Timing: only req[2]=1 from cycle 0, word=8'hFF, pattern=3'b000 → grant=4'b0100 and busy=1 for cycles 1–9; done=1 only in cycle 9 with done_ch=2 and match_cnt=0; idle at cycle 10.
- Overlap: ch0 word=8'b1010_1101, pattern=3'b101 → match high after bits 3, 5 and 8; done with match_cnt=3, done_ch=0.
- Round robin: req=4'b1011 held constantly after reset → done_ch sequence 0,1,3,0,1,3; ch2 is never granted and grant is never multi-hot.
- Saturation: CNT_W=2, word=8'h00, pattern=3'b000 → 6 raw matches, match_cnt=3.
- Reset mid-scan: assert reset_n=0 during the 4th SHIFT cycle → next cycle all outputs 0 and no done pulse; with req=4'b0110 after release, first grant is ch1.
- Input isolation: change pattern and word_in and drop req during SHIFT → result equals the value computed from the captured word and pattern.
